// File: rtl/sub_serial.sv
// Bit-serial a - b - bin, LSB first; result valid WIDTH+1 cycles after an accepted start.
// No backpressure: start is only sampled in IDLE or DONE and is ignored while busy.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             d;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Operands shift right, so bit 0 of each shift register is always the bit under work.
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_nxt = {d, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        res   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_nxt;
                    res  <= res_nxt;
                    cnt  <= cnt + 1'b1;
                    // Outputs update only here, so diff/bout never expose a partial result.
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_nxt;
                        bout  <= br_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtract-with-borrow unit; the inverse operation of the team's 4-bit ripple adder.
- Computes diff = a - b - bin over WIDTH clock cycles, LSB first, and produces borrow-out bout.
- Uses a start/busy/done handshake so a controller or testbench can issue back-to-back operations.
- Intended for reuse as the subtract path of the small ALU in later homework blocks.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend, unsigned, captured on accepted start.
- b  input  WIDTH  subtrahend, unsigned, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse when diff/bout become valid.
- diff  output  WIDTH  result a - b - bin mod 2^WIDTH.
- bout  output  1  final borrow; 1 when a < b + bin.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, busy=0, done=0, diff=0, bout=0, and internal shift/count registers cleared. Reset mid-RUN aborts the operation with no done pulse and no result update.
- States:
  - IDLE: on start=1, capture a, b and bin into internal registers, set count=0 and br=bin, then go to RUN.
  - RUN: at each edge, process bit count:
    - d = a[count] ^ b[count] ^ br
    - br_next = (~a[count] & b[count]) | (~(a[count]^b[count]) & br)
    - shift d into the internal result register from the MSB side, then count++.
  - RUN exit: the edge that processes bit WIDTH-1 moves to DONE. At that same edge, diff is loaded from the completed result and bout from br_next.
  - DONE: done=1 for exactly this one cycle, then go to IDLE. If start=1 in DONE, the operation is accepted exactly as from IDLE and the next state is RUN.
- busy=1 exactly in RUN; done=1 exactly in DONE; busy and done are never both high.
- Latency: start sampled at edge E gives busy high for cycles E..E+WIDTH-1. done is high in the cycle after edge E+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no capture, and the in-flight operation is unaffected.
- Operand changes on a, b or bin after capture have no effect on the in-flight result.
- diff and bout hold their last result until the next DONE entry or reset. They never show partial values.
- Arithmetic: unsigned, modulo 2^WIDTH. bout = 1 iff a < b + bin (integer compare with WIDTH+1 bits).
- Wrap-around: 0 - 0 - 1 gives diff=2^WIDTH-1, bout=1. 0 - (2^WIDTH-1) - 1 gives diff=0, bout=1.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, no start -> busy=0, done=0, diff=0, bout=0 for 10 cycles.
- Basic ops (WIDTH=4), each waiting for done:
  - a=0, b=0, bin=0 -> diff=0, bout=0
  - a=2, b=1, bin=1 -> diff=0, bout=0
  - a=10, b=9, bin=1 -> diff=0, bout=0
  - a=6, b=5, bin=0 -> diff=1, bout=0
  - done pulse occurs exactly 5 cycles after the start edge and lasts 1 cycle.
- Borrow/wrap:
  - a=4, b=5, bin=0 -> diff=15, bout=1
  - a=8, b=9, bin=0 -> diff=15, bout=1
  - a=12, b=13, bin=0 -> diff=15, bout=1
  - a=0, b=15, bin=1 -> diff=0, bout=1
  - a=14, b=13, bin=1 -> diff=0, bout=0
- Start while busy: start a=9, b=3, bin=0, pulse start with a=1, b=1 two cycles later -> single done, diff=6, bout=0, no second op.
- Back-to-back: assert start in the DONE cycle with a=7, b=2, bin=0 -> busy rises the next cycle, next done gives diff=5, bout=0, and the previous result is held until then.
- Reset mid-op: start a=3, b=1, then rst_n=0 at the 2nd RUN cycle -> no done, diff=0, bout=0, state IDLE; a fresh start then completes normally.
